// File: rtl/lab_MS_SV4_pack.sv
// Shared types for the lab_MS_SV4 ALU and its issue/retire queue.
package lab_MS_SV4_pack;

  typedef logic [7:0] data_y;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    VAR = 3'd4
  } opc_t;

  typedef struct packed {
    opc_t  opc;
    data_y op_a;
    data_y op_b;
  } INST_t;

  // One retired result: ALU data, the opcode that made it, and the
  // divide-by-zero flag that forces data to zero.
  typedef struct packed {
    data_y data;
    opc_t  opc;
    logic  dz;
  } RES_t;

  localparam int DEFAULT_IQ_DEPTH = 4;

endpackage

// File: rtl/iq_fifo.sv
// Synchronous FIFO of INST_t with a separately tracked occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module iq_fifo
  import lab_MS_SV4_pack::*;
#(
  parameter  int DEPTH = DEFAULT_IQ_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  INST_t         data_i,
  input  logic          pop_i,
  output INST_t         head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  INST_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointer/count; flush wins over any simultaneous push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; a flushed push never lands since the slot is unreachable.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/lab_MS_SV4.sv
// Combinational ALU. VAR is the truncated mean of the two operands.
// Division by zero returns all ones here; the issue queue masks it.
module lab_MS_SV4
  import lab_MS_SV4_pack::*;
(
  input  INST_t INST,
  output data_y ALU_out
);

  logic [8:0] sum9;

  // Pure function of the instruction word; widths are those of data_y.
  always_comb begin
    sum9    = {1'b0, INST.op_a} + {1'b0, INST.op_b};
    ALU_out = '0;
    case (INST.opc)
      ADD:     ALU_out = INST.op_a + INST.op_b;
      SUB:     ALU_out = INST.op_a - INST.op_b;
      MUL:     ALU_out = INST.op_a * INST.op_b;
      DIV:     ALU_out = (INST.op_b == '0) ? '1 : INST.op_a / INST.op_b;
      VAR:     ALU_out = sum9[8:1];
      default: ALU_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue/retire wrapper around the combinational ALU: FIFO -> EX -> RES,
// with a valid/ready result handshake and divide-by-zero masking.
module alu_issue_queue
  import lab_MS_SV4_pack::*;
#(
  parameter  int DEPTH = DEFAULT_IQ_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  INST_t         in_inst,
  output INST_t         alu_inst,
  input  data_y         alu_result,
  output logic          out_valid,
  input  logic          out_ready,
  output data_y         out_data,
  output opc_t          out_opc,
  output logic          out_dz,
  output logic [CW-1:0] count
);

  INST_t fifo_head;
  logic  fifo_full, fifo_empty;
  logic  push, pop, res_free, ex_adv, is_dz;

  logic  ex_valid_q, ex_valid_d;
  INST_t ex_inst_q, ex_inst_d;
  logic  res_valid_q, res_valid_d;
  RES_t  res_q, res_d;

  iq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (in_inst),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // in_ready looks only at FIFO fullness, so out_ready never reaches it.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;

  // Stage handshakes: RES frees when empty or drained, EX advances into a
  // free RES, and the FIFO pops whenever EX is (or is becoming) empty.
  always_comb begin
    res_free = !res_valid_q || out_ready;
    ex_adv   = ex_valid_q && res_free;
    pop      = !fifo_empty && (!ex_valid_q || ex_adv);
  end

  // Idle EX presents an all-zero instruction to the ALU.
  assign alu_inst = ex_valid_q ? ex_inst_q : '0;
  assign is_dz    = (ex_inst_q.opc == DIV) && (ex_inst_q.op_b == '0);

  // EX next state: load on pop, drain on advance, clear on flush.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_inst_d  = ex_inst_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (pop) begin
      ex_valid_d = 1'b1;
      ex_inst_d  = fifo_head;
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end
  end

  // RES next state: capture on advance, otherwise hold until accepted.
  always_comb begin
    res_valid_d = res_valid_q;
    res_d       = res_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (ex_adv) begin
      res_valid_d = 1'b1;
      res_d.data  = is_dz ? '0 : alu_result;
      res_d.opc   = ex_inst_q.opc;
      res_d.dz    = is_dz;
    end else if (out_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // EX and RES registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_inst_q   <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_inst_q   <= ex_inst_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = res_valid_q;
  assign out_data  = res_q.data;
  assign out_opc   = res_q.opc;
  assign out_dz    = res_q.dz;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue driving the real ALU, with a
// result scoreboard filled as instructions are accepted.
module tb_alu_issue_queue;
  import lab_MS_SV4_pack::*;

  localparam int DEPTH = DEFAULT_IQ_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  INST_t         in_inst;
  INST_t         alu_inst;
  data_y         alu_result;
  logic          out_valid;
  logic          out_ready;
  data_y         out_data;
  opc_t          out_opc;
  logic          out_dz;
  logic [CW-1:0] count;

  int   compared   = 0;
  int   mismatched = 0;
  RES_t sb[$];
  data_y heldData;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .alu_inst   (alu_inst),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_opc    (out_opc),
    .out_dz     (out_dz),
    .count      (count)
  );

  lab_MS_SV4 alu (
    .INST    (alu_inst),
    .ALU_out (alu_result)
  );

  always #5 clk = ~clk;

  // Guards against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result for an instruction, written from the ALU's definition.
  function automatic RES_t model(INST_t i);
    RES_t r;
    logic [8:0] s;
    r.opc = i.opc;
    r.dz  = 1'b0;
    s     = {1'b0, i.op_a} + {1'b0, i.op_b};
    case (i.opc)
      ADD: r.data = i.op_a + i.op_b;
      SUB: r.data = i.op_a - i.op_b;
      MUL: r.data = 8'(16'(i.op_a) * 16'(i.op_b));
      DIV: begin
        r.dz   = (i.op_b == 8'd0);
        r.data = r.dz ? 8'd0 : i.op_a / i.op_b;
      end
      VAR:     r.data = s[8:1];
      default: r.data = 8'd0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock: at the falling edge retire/compare any transferring result and
  // record an accepted instruction, then return just after the rising edge.
  task automatic clockCycle();
    RES_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("stale_result", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_data", 32'(out_data), 32'(e.data));
        checkOutput("sb_opc",  32'(out_opc),  32'(e.opc));
        checkOutput("sb_dz",   32'(out_dz),   32'(e.dz));
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(in_inst));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(logic v, opc_t o, data_y a, data_y b);
    in_valid     = v;
    in_inst.opc  = o;
    in_inst.op_a = a;
    in_inst.op_b = b;
    clockCycle();
  endtask

  task automatic drain(string tag, int maxCycles);
    int n = 0;
    while (sb.size() > 0 && n < maxCycles) begin
      clockCycle();
      n++;
    end
    checkOutput(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    out_ready = 1'b0;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_count",     32'(count),     32'd0);
    checkOutput("rst_alu_inst",  32'(alu_inst),  32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      checkOutput("idle_in_ready",  32'(in_ready),  32'd1);
      checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
      checkOutput("idle_count",     32'(count),     32'd0);
      checkOutput("idle_alu_inst",  32'(alu_inst),  32'd0);
      clockCycle();
    end

    // Single ADD and its latency.
    $display("[TB] single ADD");
    out_ready = 1'b1;
    applyStimulus(1'b1, ADD, 8'd6, 8'd3);
    in_valid = 1'b0;
    checkOutput("add_count_e0",  32'(count),     32'd1);
    checkOutput("add_valid_e0",  32'(out_valid), 32'd0);
    clockCycle();
    checkOutput("add_alu_inst",  32'(alu_inst),  32'({ADD, 8'd6, 8'd3}));
    checkOutput("add_valid_e1",  32'(out_valid), 32'd0);
    clockCycle();
    checkOutput("add_valid_e2",  32'(out_valid), 32'd1);
    checkOutput("add_data",      32'(out_data),  32'd9);
    checkOutput("add_opc",       32'(out_opc),   32'(ADD));
    checkOutput("add_dz",        32'(out_dz),    32'd0);
    clockCycle();
    checkOutput("add_valid_e3",  32'(out_valid), 32'd0);

    // Back-to-back SUB, MUL, VAR at full throughput.
    $display("[TB] back-to-back");
    applyStimulus(1'b1, SUB, 8'd10, 8'd4);
    applyStimulus(1'b1, MUL, 8'd3,  8'd5);
    applyStimulus(1'b1, VAR, 8'd7,  8'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("b2b_valid", 32'(out_valid), 32'd1);
      clockCycle();
    end
    checkOutput("b2b_sb_empty",  32'(sb.size()), 32'd0);
    checkOutput("b2b_valid_end", 32'(out_valid), 32'd0);

    // Divide by zero versus a normal divide.
    $display("[TB] divide");
    applyStimulus(1'b1, DIV, 8'd8, 8'd0);
    applyStimulus(1'b1, DIV, 8'd8, 8'd2);
    in_valid = 1'b0;
    drain("div_drain", 10);

    // Stall: fill FIFO, EX and RES with out_ready low.
    $display("[TB] stall and fill");
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++)
      applyStimulus(1'b1, (k % 2 == 0) ? ADD : MUL, 8'(k + 2), 8'(k + 1));
    checkOutput("full_in_ready",  32'(in_ready),  32'd0);
    checkOutput("full_count",     32'(count),     32'(DEPTH));
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("full_alu_inst",  32'(alu_inst),  32'({MUL, 8'd3, 8'd2}));
    heldData = out_data;
    applyStimulus(1'b1, SUB, 8'd99, 8'd1);
    applyStimulus(1'b1, SUB, 8'd98, 8'd1);
    in_valid = 1'b0;
    checkOutput("stall_hold_data", 32'(out_data),  32'(heldData));
    checkOutput("stall_hold_cnt",  32'(count),     32'(DEPTH));
    checkOutput("stall_in_ready",  32'(in_ready),  32'd0);
    out_ready = 1'b1;
    drain("stall_drain", 20);
    clockCycle();
    checkOutput("stall_end_valid", 32'(out_valid), 32'd0);
    checkOutput("stall_end_count", 32'(count),     32'd0);

    // Flush with work in flight, plus a push that must be discarded.
    $display("[TB] flush");
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, ADD, 8'(k), 8'd1);
    checkOutput("pre_flush_count", 32'(count),     32'd3);
    checkOutput("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    applyStimulus(1'b1, SUB, 8'd50, 8'd5);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_count",    32'(count),     32'd0);
    checkOutput("flush_valid",    32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clockCycle();
      checkOutput("flush_no_stale", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream.
    $display("[TB] async reset");
    applyStimulus(1'b1, ADD, 8'd1, 8'd1);
    applyStimulus(1'b1, ADD, 8'd2, 8'd2);
    applyStimulus(1'b1, ADD, 8'd3, 8'd3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("prerst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid",    32'(out_valid), 32'd0);
    checkOutput("arst_count",    32'(count),     32'd0);
    checkOutput("arst_alu_inst", 32'(alu_inst),  32'd0);
    checkOutput("arst_in_ready", 32'(in_ready),  32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(1'b1, SUB, 8'd20, 8'd7);
    in_valid = 1'b0;
    drain("post_rst_drain", 10);
    clockCycle();
    checkOutput("post_rst_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Upstream issue/retire stage for the combinational ALU (lab_MS_SV4). Buffers incoming INST_t instructions in a small FIFO and issues one per cycle into an execute register that drives the ALU. Captures the ALU result into a result register with a valid/ready output handshake. Flags divide-by-zero so the ALU never produces an undefined DIV result downstream.

Parameters:
DEPTH, 4, instruction FIFO entries; power of 2, >= 2
CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of FIFO, EX and RES
in_valid  in  1  upstream instruction valid
in_ready  out  1  FIFO can accept (= !full)
in_inst  in  INST_t  instruction {opc, op_a, op_b}
alu_inst  out  INST_t  EX register contents to ALU INST port
alu_result  in  data_y  ALU_out, combinational from alu_inst
out_valid  out  1  result register valid
out_ready  in  1  downstream accepts result
out_data  out  data_y  registered result
out_opc  out  opc type  opcode of the retired instruction
out_dz  out  1  divide-by-zero on the retired instruction
count  out  CW  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n=0, async): FIFO pointers and count = 0; EX valid = 0; RES valid = 0. alu_inst, out_data, out_opc and out_dz all = 0. in_ready = 1.
- Push: in_valid && in_ready at an edge writes in_inst at wr_ptr. in_ready = !full and does not depend on pop, so there is no comb path from out_ready to in_ready.
- Pipeline control: res_free = !out_valid || out_ready; ex_adv = ex_valid && res_free; pop = !empty && (!ex_valid || ex_adv).
- Pop loads the FIFO head into EX and sets ex_valid. ex_adv without pop clears ex_valid.
- EX contents go straight to alu_inst. When ex_valid = 0, alu_inst is driven all-zero.
- On ex_adv, RES captures the following and sets out_valid:
  - out_data = alu_result, or 0 when opc==DIV && op_b==0;
  - out_dz = (opc==DIV && op_b==0);
  - out_opc = EX opc.
- out_valid clears on out_ready with no new ex_adv.
- Output hold: out_data, out_opc and out_dz stay stable while out_valid && !out_ready.
- Latency: with the pipeline empty, an instruction pushed at edge N is in EX after N+1. It is in RES, with out_valid high, after N+2.
- Throughput: 1 instruction/cycle with out_ready held high.
- Order: strict FIFO order; no reordering, no dropping.
- Empty FIFO: no pop, and no bypass from in_inst to EX.
- Full FIFO with a pop in the same cycle: in_ready is still 0 that cycle; the freed slot is visible next cycle.
- Pointers: wrap modulo DEPTH. count is tracked separately; full = (count==DEPTH), empty = (count==0).
- flush: at the edge, clears count, pointers, ex_valid and out_valid. flush dominates a simultaneous push/pop, and the pushed instruction is discarded.
- Reset mid-operation: all in-flight instructions are lost with no partial output. out_valid is 0 immediately on rst_n falling (async).
- Widths: arithmetic width and truncation are those of data_y as the ALU produces them; this block adds no width conversion.

Decomposition:
- The INST_t, data_y and opcode enum types are defined in lab_MS_SV4_pack. Add the following to lab_MS_SV4_pack:
  - RES_t struct {data_y data; opc; logic dz};
  - a DEFAULT_IQ_DEPTH = 4 localparam.
- One sub-module: iq_fifo, a parameterised synchronous FIFO of INST_t with push/pop/full/empty/count.
- EX, RES and the control logic live in alu_issue_queue. The bench instantiates alu_issue_queue with lab_MS_SV4 connected alu_inst->INST and ALU_out->alu_result.

Test Plan:
- Reset release, idle: in_ready=1, out_valid=0, count=0, alu_inst=0, for 5 cycles.
- Single ADD op_a=6 op_b=3 pushed at edge 0, out_ready=1 -> out_valid high after edge 2, out_data=9, out_opc=ADD, out_dz=0, then low next cycle.
- Back-to-back SUB 10,4; MUL 3,5; VAR 7,4, out_ready=1 -> results 6, 15, 5 on consecutive cycles in order.
- DIV 8,0 then DIV 8,2 -> first result out_data=0 with out_dz=1; second result out_data=4 with out_dz=0.
- out_ready=0 while pushing DEPTH+2 instructions:
  - FIFO fills, in_ready=0 with count=DEPTH, and one result each is held in EX and RES;
  - out_data is stable while stalled;
  - releasing out_ready drains all results in order.
- Flush and async reset:
  - flush with count=3 and out_valid=1 -> next cycle count=0, out_valid=0, and no stale results appear afterwards;
  - rst_n dropped mid-stream -> out_valid=0 without waiting for a clock edge.
